rc4_nibble_ctrl: RTL

- Sequencer for the 4-bit RC4 swap datapath. Owns a 16-entry x 4-bit S-box register file.
- Runs, in order: S-box init, key scheduling (KSA) with one swap per index, then keystream generation (PRGA).
- Emits one 4-bit keystream nibble per valid/ready handshake to the encrypt/decrypt stage of the microprocessor.

---
 rtl/rc4_nibble_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rc4_nibble_ctrl.sv
// rc4_nibble_ctrl: 4-bit RC4 sequencer (S-box init, KSA, PRGA).
// Ports: clk, reset (async low), start/stop, key, busy, init_done, ks_valid/ks_ready/ks_out.
module rc4_nibble_ctrl #(
  parameter int KEY_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [4*KEY_LEN-1:0] key,
  output logic                 busy,
  output logic                 init_done,
  output logic                 ks_valid,
  input  logic                 ks_ready,
  output logic [3:0]           ks_out
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA_J,
    KSA_SW,
    P_IJ,
    P_SW,
    P_OUT,
    P_HOLD
  } state_t;

  state_t st;

  logic [3:0] s [16];
  logic [3:0] i;
  logic [3:0] j;
  logic [KEY_LEN-1:0][3:0] keyr;

  logic [3:0] kn;
  logic [3:0] ip1;
  logic [3:0] oidx;

  assign ip1  = i + 4'd1;
  assign oidx = s[i] + s[j];

  // key nibble for index i mod KEY_LEN
  always_comb begin
    kn = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (int'(i) % KEY_LEN == k) kn = keyr[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      i         <= '0;
      j         <= '0;
      keyr      <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      ks_valid  <= 1'b0;
      ks_out    <= '0;
      for (int k = 0; k < 16; k++) s[k] <= '0;
    end else if (stop) begin
      // abort wins everywhere; S, i, j are left as they are
      st        <= IDLE;
      busy      <= 1'b0;
      init_done <= 1'b0;
      ks_valid  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            keyr <= key;
            i    <= '0;
            j    <= '0;
            busy <= 1'b1;
            st   <= INIT;
          end
        end
        INIT: begin
          s[i] <= i;
          i    <= ip1;
          if (i == 4'd15) st <= KSA_J;
        end
        KSA_J: begin
          j  <= j + s[i] + kn;
          st <= KSA_SW;
        end
        KSA_SW: begin
          s[i] <= s[j];
          s[j] <= s[i];
          if (i == 4'd15) begin
            i         <= '0;
            j         <= '0;
            init_done <= 1'b1;
            st        <= P_IJ;
          end else begin
            i  <= ip1;
            st <= KSA_J;
          end
        end
        P_IJ: begin
          i  <= ip1;
          j  <= j + s[ip1];
          st <= P_SW;
        end
        P_SW: begin
          s[i] <= s[j];
          s[j] <= s[i];
          st   <= P_OUT;
        end
        P_OUT: begin
          ks_out   <= s[oidx];
          ks_valid <= 1'b1;
          st       <= P_HOLD;
        end
        P_HOLD: begin
          if (ks_ready) begin
            ks_valid <= 1'b0;
            st       <= P_IJ;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
